// File: rtl/truth_table_checker.sv
// Truth-table checker: walks {a,b,c} through all eight vectors, samples the
// response y after SETTLE cycles and compares it with a latched expected table.
module truth_table_checker #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] tt,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic       fail_valid,
    output logic [2:0] fail_vec
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t     state;
    logic [2:0] vec;
    logic [3:0] settle_cnt;
    logic [7:0] tt_lat;
    logic       mismatch;
    logic [3:0] err_next;

    // err_next feeds pass on the final SAMPLE so pass is valid together with done
    always_comb begin
        mismatch = (y != tt_lat[vec]);
        err_next = err_cnt + {3'b000, mismatch};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            vec        <= 3'd0;
            settle_cnt <= 4'd0;
            tt_lat     <= 8'd0;
            a          <= 1'b0;
            b          <= 1'b0;
            c          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= 4'd0;
            fail_valid <= 1'b0;
            fail_vec   <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= DRIVE;
                        tt_lat     <= tt;
                        vec        <= 3'd0;
                        settle_cnt <= 4'd0;
                        {a, b, c}  <= 3'b000;
                        busy       <= 1'b1;
                        err_cnt    <= 4'd0;
                        pass       <= 1'b0;
                        fail_valid <= 1'b0;
                        fail_vec   <= 3'd0;
                    end
                end
                DRIVE: begin
                    settle_cnt <= 4'd0;
                    state      <= (SETTLE > 0) ? WAIT : SAMPLE;
                end
                WAIT: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    err_cnt <= err_next;
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= vec;
                    end
                    // vec stays at 7 on the last vector so a/b/c hold through DONE
                    if (vec == 3'd7) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 4'd0);
                    end else begin
                        vec       <= vec + 3'd1;
                        {a, b, c} <= vec + 3'd1;
                        state     <= DRIVE;
                    end
                end
                DONE: begin
                    {a, b, c} <= 3'b000;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench for truth_table_checker: expected run results are queued
// when a run is launched and compared when done pulses.
module tb_truth_table_checker;

    localparam int SETTLE    = 1;
    localparam int VEC_CYC   = SETTLE + 2;
    localparam int DONE_CYC  = 8 * VEC_CYC + 1;
    localparam int MAX_CYC   = DONE_CYC + 20;

    typedef struct {
        logic [3:0] err;
        logic       fv;
        logic [2:0] fvec;
        logic       pass;
    } exp_t;

    logic       clk;
    logic       rstn;
    logic       start;
    logic [7:0] tt;
    logic       y;
    logic       a, b, c;
    logic       busy, done, pass;
    logic [3:0] err_cnt;
    logic       fail_valid;
    logic [2:0] fail_vec;
    bit         y_stuck;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    truth_table_checker #(.SETTLE(SETTLE)) dut (
        .clk(clk), .rstn(rstn), .start(start), .tt(tt), .y(y),
        .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_valid(fail_valid), .fail_vec(fail_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block under test: (a&b)|c, or a stuck-at-1 output
    always_comb y = y_stuck ? 1'b1 : ((a & b) | c);

    function automatic exp_t model(input logic [7:0] tt_val, input bit stuck);
        exp_t e;
        e.err = 4'd0; e.fv = 1'b0; e.fvec = 3'd0;
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            logic       yv;
            vv = 3'(v);
            yv = stuck ? 1'b1 : ((vv[2] & vv[1]) | vv[0]);
            if (yv != tt_val[v]) begin
                if (!e.fv) begin e.fv = 1'b1; e.fvec = vv; end
                e.err = e.err + 4'd1;
            end
        end
        e.pass = (e.err == 4'd0);
        return e;
    endfunction

    task automatic check_all_zero(input string name);
        logic [13:0] obs;
        obs = {a, b, c, busy, done, pass, err_cnt, fail_valid, fail_vec};
        checks++;
        if (obs !== 14'd0) begin
            errors++;
            $display("[TB] FAIL %s: outputs=%h expected=0", name, obs);
        end
    endtask

    task automatic run_vectors(input string name, input logic [7:0] tt_val, input bit stuck,
                               input int repulse_cyc, input int tt_change_cyc, input int abort_cyc);
        exp_t exp_r, got;
        int   cyc;
        bit   seen;
        tt      = tt_val;
        y_stuck = stuck;
        if (abort_cyc == 0) sb.push_back(model(tt_val, stuck));
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        while (cyc <= MAX_CYC && !seen) begin
            if (abort_cyc != 0 && cyc == abort_cyc) begin
                #2 rstn = 1'b0;
                #1 check_all_zero({name, "_abort_async"});
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checks++;
                    if (done !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL %s_abort_done: done=%b expected=0", name, done);
                    end
                end
                rstn = 1'b1;
                check_all_zero({name, "_abort_after"});
                return;
            end
            if (cyc < DONE_CYC) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL %s_busy cyc %0d: busy=%b expected=1", name, cyc, busy);
                end
                if ((cyc - 1) % VEC_CYC == 0) begin
                    checks++;
                    if ({a, b, c} !== 3'((cyc - 1) / VEC_CYC)) begin
                        errors++;
                        $display("[TB] FAIL %s_abc cyc %0d: abc=%b expected=%b", name, cyc,
                                 {a, b, c}, 3'((cyc - 1) / VEC_CYC));
                    end
                end
            end
            start = (cyc == repulse_cyc);
            if (cyc == tt_change_cyc) tt = ~tt_val;
            if (done === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (cyc != DONE_CYC) begin
                    errors++;
                    $display("[TB] FAIL %s_done_cycle: cycle=%0d expected=%0d", name, cyc, DONE_CYC);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL %s_scoreboard: queue empty, expected one entry", name);
                end else begin
                    exp_r = sb.pop_front();
                    got.err = err_cnt; got.fv = fail_valid; got.fvec = fail_vec; got.pass = pass;
                    if (got.err !== exp_r.err || got.fv !== exp_r.fv ||
                        got.fvec !== exp_r.fvec || got.pass !== exp_r.pass) begin
                        errors++;
                        $display("[TB] FAIL %s_result: err=%0d fv=%b fvec=%0d pass=%b expected err=%0d fv=%b fvec=%0d pass=%b",
                                 name, got.err, got.fv, got.fvec, got.pass,
                                 exp_r.err, exp_r.fv, exp_r.fvec, exp_r.pass);
                    end
                    // results must hold once the run is over
                    repeat (2) @(negedge clk);
                    checks++;
                    if (done !== 1'b0 || busy !== 1'b0 || err_cnt !== exp_r.err ||
                        pass !== exp_r.pass || {a, b, c} !== 3'b000) begin
                        errors++;
                        $display("[TB] FAIL %s_hold: done=%b busy=%b err=%0d pass=%b abc=%b expected 0 0 %0d %b 000",
                                 name, done, busy, err_cnt, pass, {a, b, c}, exp_r.err, exp_r.pass);
                    end
                end
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: no done within %0d cycles", name, MAX_CYC);
        end
    endtask

    task automatic test_power_on();
        rstn = 1'b0;
        #1 check_all_zero("power_on_reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_pass_run();
        run_vectors("pass_ea", 8'hEA, 1'b0, 0, 0, 0);
    endtask

    task automatic test_single_error();
        run_vectors("err_eb", 8'hEB, 1'b0, 0, 0, 0);
    endtask

    task automatic test_all_errors();
        run_vectors("err_15", 8'h15, 1'b0, 0, 0, 0);
    endtask

    task automatic test_reset();
        checks++;
        if (err_cnt !== 4'd8) begin
            errors++;
            $display("[TB] FAIL reset_precondition: err_cnt=%0d expected=8", err_cnt);
        end
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 check_all_zero("reset_mid_cycle");
        @(negedge clk) rstn = 1'b1;
    endtask

    task automatic test_y_stuck();
        run_vectors("y_stuck", 8'hEA, 1'b1, 0, 0, 0);
    endtask

    task automatic test_robust();
        run_vectors("repulse", 8'hEA, 1'b0, 1 + 2 * VEC_CYC, 5, 0);
        run_vectors("abort", 8'hEA, 1'b0, 0, 0, 1 + 3 * VEC_CYC);
        run_vectors("after_abort", 8'hEB, 1'b0, 0, 0, 0);
    endtask

    initial begin
        start   = 1'b0;
        tt      = 8'h00;
        y_stuck = 1'b0;
        test_power_on();
        test_pass_run();
        test_single_error();
        test_all_errors();
        test_reset();
        test_y_stuck();
        test_robust();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
